// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU operation per request (single pass or shift-add MUL) and returns a registered response.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_op opcode, req_a/req_b operands
//   rsp_valid/rsp_ready           response handshake; rsp_data result, rsp_flags {N,O,Z,C}, rsp_err illegal opcode
//   alu_a, alu_b, alu_cin, alu_sel  drive to the external combinational ALU
//   alu_out, alu_cout, alu_status   results back from the ALU ({N,O,Z,C} in status)
// Build option: define ALU_SEQ_MUL_EN to enable opcode 8 (MUL); otherwise it answers as illegal.
module alu_op_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic        alu_cin,
   output logic [4:0]  alu_sel,
   input  logic [63:0] alu_out,
   input  logic        alu_cout,
   input  logic [3:0]  alu_status
);
   typedef enum logic [1:0] {IDLE, EXEC, MUL_STEP, RESP} state_t;
   state_t state;
   // set when a disabled opcode passes through EXEC so it answers as illegal with normal latency
   logic bad;
`ifdef ALU_SEQ_MUL_EN
   logic [63:0] q;
   logic [5:0]  cnt;
   logic [63:0] p_next;
   logic        done;
   // alu_a holds the partial product P, alu_b holds the shifted multiplicand M
   assign p_next = q[0] ? alu_out : alu_a;
   assign done   = (q[63:1] == 63'd0) || (cnt == 6'd63);
`endif
   function automatic logic [4:0] op_sel(input logic [3:0] op);
      case (op)
         4'd0:    op_sel = 5'b10000;
         4'd1:    op_sel = 5'b10010;
         4'd2:    op_sel = 5'b01000;
         4'd3:    op_sel = 5'b00100;
         4'd4:    op_sel = 5'b01100;
         4'd5:    op_sel = 5'b01011;
         4'd6:    op_sel = 5'b11000;
         4'd7:    op_sel = 5'b10100;
         default: op_sel = 5'b00000;
      endcase
   endfunction
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bad       <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cin   <= 1'b0;
         alu_sel   <= '0;
`ifdef ALU_SEQ_MUL_EN
         q         <= '0;
         cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               if (req_op < 4'd8) begin
                  alu_a   <= req_a;
                  alu_b   <= req_b;
                  alu_sel <= op_sel(req_op);
                  alu_cin <= (req_op == 4'd1);
                  bad     <= 1'b0;
                  state   <= EXEC;
               end
`ifdef ALU_SEQ_MUL_EN
               else if (req_op == 4'd8) begin
                  alu_b   <= req_a;
                  alu_sel <= 5'b10000;
                  q       <= req_b;
                  cnt     <= '0;
                  state   <= MUL_STEP;
               end
`else
               else if (req_op == 4'd8) begin
                  bad   <= 1'b1;
                  state <= EXEC;
               end
`endif
               else begin
                  rsp_data  <= '0;
                  rsp_flags <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            EXEC: begin
               rsp_data  <= bad ? 64'd0 : alu_out;
               // carry is reported if either ALU carry indication is set
               rsp_flags <= bad ? 4'd0 : {alu_status[3:1], alu_status[0] | alu_cout};
               rsp_err   <= bad;
               alu_a     <= '0;
               alu_b     <= '0;
               alu_cin   <= 1'b0;
               alu_sel   <= '0;
               state     <= RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_STEP: begin
               alu_a <= p_next;
               alu_b <= alu_b << 1;
               q     <= q >> 1;
               cnt   <= cnt + 6'd1;
               if (done) begin
                  rsp_data  <= p_next;
                  rsp_flags <= {p_next[63], 1'b0, p_next == 64'd0, 1'b0};
                  rsp_err   <= 1'b0;
                  alu_a     <= '0;
                  alu_b     <= '0;
                  alu_sel   <= '0;
                  state     <= RESP;
               end
            end
`endif
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
   logic [3:0]  req_op = '0;
   logic [63:0] req_a = '0, req_b = '0;
   logic        req_ready, rsp_valid, rsp_err, alu_cin, alu_cout;
   logic [63:0] rsp_data, alu_a, alu_b, alu_out;
   logic [3:0]  rsp_flags, alu_status;
   logic [4:0]  alu_sel;
   typedef struct {logic [63:0] data; logic [3:0] flags; logic err; int lat;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   logic [4:0] sel_tab [8] = '{5'b10000, 5'b10010, 5'b01000, 5'b00100, 5'b01100, 5'b01011, 5'b11000, 5'b10100};

   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_sel(alu_sel), .alu_out(alu_out), .alu_cout(alu_cout), .alu_status(alu_status));

   always #5 clk = ~clk;

   // behavioural external ALU
   always_comb begin
      logic [63:0] x, y;
      logic [64:0] s;
      logic ov;
      x = alu_sel[0] ? ~alu_a : alu_a;
      y = alu_sel[1] ? ~alu_b : alu_b;
      s = '0;
      ov = 1'b0;
      alu_out = '0;
      alu_cout = 1'b0;
      case (alu_sel[4:2])
         3'd1: alu_out = x | y;
         3'd2: alu_out = x & y;
         3'd3: alu_out = x ^ y;
         3'd4: begin
            s = {1'b0, x} + {1'b0, y} + {64'd0, alu_cin};
            alu_out = s[63:0];
            alu_cout = s[64];
            ov = (x[63] == y[63]) && (s[63] != x[63]);
         end
         3'd5: alu_out = x >> y[5:0];
         3'd6: alu_out = x << y[5:0];
         default: alu_out = '0;
      endcase
      alu_status = {alu_out[63], ov, alu_out == 64'd0, alu_cout};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      logic [64:0] s;
      logic [63:0] r;
      logic c, o;
      int steps;
      r = '0; c = 1'b0; o = 1'b0; s = '0;
      e.err = 1'b0;
      e.lat = 2;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[63:0]; c = s[64];
            o = (a[63] == b[63]) && (r[63] != a[63]);
         end
         4'd1: begin
            r = a - b; c = (a >= b);
            o = (a[63] != b[63]) && (r[63] != a[63]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a | b);
         4'd6: r = a << b[5:0];
         4'd7: r = a >> b[5:0];
`ifdef ALU_SEQ_MUL_EN
         4'd8: begin
            r = a * b;
            steps = 1;
            for (int i = 0; i < 64; i++) if (b[i]) steps = i + 1;
            e.lat = steps + 1;
         end
`else
         4'd8: e.err = 1'b1;
`endif
         default: begin
            e.err = 1'b1;
            e.lat = 1;
         end
      endcase
      e.data = e.err ? 64'd0 : r;
      e.flags = e.err ? 4'd0 : {r[63], o, r == 64'd0, c};
      return e;
   endfunction

   task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
      exp_t e;
      int n, w;
      logic [63:0] d0;
      logic [3:0] f0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      w = 0;
      while (!req_ready && w < 100) begin @(negedge clk); w++; end
      check({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      sb.push_back(model(op, a, b));
      #1 req_valid = 1'b0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_op = 4'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1 && op < 4'd8) begin
            check({tag, " alu_sel"}, {59'd0, alu_sel}, {59'd0, sel_tab[op]});
            check({tag, " alu_cin"}, {63'd0, alu_cin}, {63'd0, op == 4'd1});
            check({tag, " alu_a"}, alu_a, a);
            check({tag, " alu_b"}, alu_b, b);
         end
      end while (!rsp_valid && n < 200);
      e = sb[0];
      check({tag, " latency"}, 64'(n), 64'(e.lat));
      if (rsp_valid) begin
         e = sb.pop_front();
         check({tag, " rsp_data"}, rsp_data, e.data);
         check({tag, " rsp_flags"}, {60'd0, rsp_flags}, {60'd0, e.flags});
         check({tag, " rsp_err"}, {63'd0, rsp_err}, {63'd0, e.err});
         check({tag, " resp alu_sel"}, {59'd0, alu_sel}, 64'd0);
         check({tag, " resp alu_a"}, alu_a, 64'd0);
         d0 = e.data; f0 = e.flags;
         repeat (hold) begin
            @(negedge clk);
            check({tag, " hold data"}, rsp_data, d0);
            check({tag, " hold flags"}, {60'd0, rsp_flags}, {60'd0, f0});
            check({tag, " hold valid"}, {63'd0, rsp_valid}, 64'd1);
            check({tag, " hold req_ready"}, {63'd0, req_ready}, 64'd0);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check({tag, " done rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
         check({tag, " done req_ready"}, {63'd0, req_ready}, 64'd1);
      end
   endtask

   initial begin
      int seen;
      repeat (2) @(negedge clk);
      check("reset req_ready", {63'd0, req_ready}, 64'd1);
      check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("reset rsp_data", rsp_data, 64'd0);
      check("reset alu_sel", {59'd0, alu_sel}, 64'd0);
      rst_n = 1'b1;
      run("sub_5_7", 4'd1, 64'd5, 64'd7, 0);
      run("add_wrap", 4'd0, '1, 64'd1, 10);
      run("mul_1234", 4'd8, 64'h1234, 64'h10, 0);
      run("shr_43", 4'd7, 64'h8000_0000_0000_0000, 64'h43, 0);
      run("ill_12", 4'd12, 64'd1, 64'd2, 0);
      run("and", 4'd2, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 0);
      run("or", 4'd3, 64'h0000_1111_0000_2222, 64'hA000_0000_3333_0000, 0);
      run("xor", 4'd4, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, 0);
      run("nor", 4'd5, 64'd0, 64'd0, 0);
      run("shl", 4'd6, 64'd1, 64'h7F, 0);
      run("add_ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
      run("sub_eq", 4'd1, 64'd9, 64'd9, 2);
      run("mul_b0", 4'd8, 64'd5, 64'd0, 0);
      run("mul_max", 4'd8, 64'd3, 64'h8000_0000_0000_0000, 0);
      run("mul_mix", 4'd8, 64'hDEAD_BEEF, 64'h1_0001, 0);
      run("ill_9", 4'd9, 64'd3, 64'd4, 0);
      run("ill_15", 4'd15, 64'd3, 64'd4, 1);
      // reset while an operation is in flight
      @(negedge clk);
      req_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      req_op = 4'd8;
`else
      req_op = 4'd0;
`endif
      req_a = 64'd3; req_b = '1;
      @(posedge clk);
      #1 req_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      repeat (19) @(posedge clk);
      #1 check("mid_mul alu_sel", {59'd0, alu_sel}, 64'h10);
`endif
      #2 rst_n = 1'b0;
      #1;
      check("rst rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst req_ready", {63'd0, req_ready}, 64'd1);
      check("rst alu_sel", {59'd0, alu_sel}, 64'd0);
      check("rst alu_a", alu_a, 64'd0);
      check("rst alu_b", alu_b, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      check("rst no response", 64'(seen), 64'd0);
      check("scoreboard empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 req_valid  input  1  request present.
REQ-003 req_ready  output  1  request accepted when req_valid&req_ready at clk rise.
REQ-004 req_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SHL, 7 SHR, 8 MUL; 9-15 illegal.
REQ-005 req_a, req_b  input  64 each  operands.
REQ-006 rsp_valid  output  1  response present; rsp_ready  input  1  response consumed.
REQ-007 rsp_data  output  64  result; rsp_flags  output  4  {N,O,Z,C} as [3:0]; rsp_err  output  1  illegal/disabled opcode.
REQ-008 alu_a, alu_b  output  64 each; alu_cin  output  1; alu_sel  output  5  ALU drive (sel[0] invert a, sel[1] invert b, sel[4:2]: 0 zero, 1 OR, 2 AND, 3 XOR, 4 ADD, 5 SHR, 6 SHL).
REQ-009 alu_out  input  64; alu_cout  input  1; alu_status  input  4  combinational ALU results, [0]C [1]Z [2]O [3]N.

Function
REQ-010 FSM states SHALL be IDLE, EXEC, MUL_STEP, RESP; req_ready SHALL be 1 only in IDLE.
REQ-011 On accept, the block SHALL latch op and operands; legal non-MUL op -> EXEC; MUL -> MUL_STEP; illegal op -> RESP with rsp_data=0, rsp_flags=0, rsp_err=1.
REQ-012 In EXEC, the block SHALL drive the ALU from latched operands: ADD sel=10000 cin=0; SUB sel=10010 cin=1; AND 01000; OR 00100; XOR 01100; NOR sel=01011 (~a&~b); SHL 11000; SHR 10100; cin=0 except SUB.
REQ-013 At the end of EXEC, the block SHALL capture alu_out into rsp_data and alu_status into rsp_flags, with rsp_err=0, and go to RESP; accept-to-rsp_valid latency is exactly 2 cycles.
REQ-014 MUL SHALL compute the low 64 bits of a*b by shift-add: P=0, M=a, Q=b; each MUL_STEP cycle drives alu_a=P, alu_b=M, sel=10000, cin=0; if Q[0]=1, P<=alu_out; then M<=M<<1, Q<=Q>>1.
REQ-015 MUL SHALL leave MUL_STEP when Q (after shift) is 0 or after 64 steps, whichever is first; b=0 SHALL take exactly 1 step; max latency is 65 cycles from accept.
REQ-016 MUL response SHALL be rsp_data=P, flags Z=(P==0), N=P[63], C=0, O=0, rsp_err=0.
REQ-017 In RESP, rsp_valid=1 and rsp_data/rsp_flags/rsp_err SHALL be stable until rsp_ready=1; then -> IDLE; no request is accepted in the same cycle.
REQ-018 In IDLE and RESP, alu_a=0, alu_b=0, alu_cin=0, alu_sel=00000.
REQ-019 Shift amounts SHALL be req_b[5:0]; upper bits of req_b are ignored by the ALU and SHALL be passed unchanged.
REQ-020 req_* inputs SHALL be ignored outside IDLE; changes after accept SHALL not affect the in-flight operation.

Reset
REQ-021 With rst_n=0, the block SHALL immediately enter IDLE and set req_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, and all alu_* outputs to 0.
REQ-022 Reset during EXEC, MUL_STEP, or RESP SHALL discard the operation with no response.

Configuration
REQ-023 Macro ALU_SEQ_MUL_EN: when defined, opcode 8 SHALL execute per REQ-014..016; when undefined, MUL_STEP logic SHALL be absent and opcode 8 SHALL respond as illegal (rsp_err=1, data 0, 2-cycle latency).

Verification
REQ-024 SUB a=5, b=7 -> rsp_data=0xFFFFFFFFFFFFFFFE, N=1, Z=0, C=0, rsp_valid 2 cycles after accept.
REQ-025 ADD a=0xFFFFFFFFFFFFFFFF, b=1 -> rsp_data=0, Z=1, C=1.
REQ-026 MUL a=0x1234, b=0x10 (MUL_EN defined) -> rsp_data=0x12340 after 5 steps; without macro -> rsp_err=1, data 0.
REQ-027 SHR a=0x8000000000000000, b=0x43 -> rsp_data=0x1000000000000000; opcode 12 -> rsp_err=1.
REQ-028 ADD with rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> req_ready=1 next cycle.
REQ-029 Assert rst_n=0 mid-MUL (step 20) -> immediately rsp_valid=0, req_ready=1, alu_sel=0; no response after release.
